// File: rtl/framebuffer_fill_engine_pkg.sv
// Shared framebuffer geometry, command layout and FSM encoding.
// dvi_controller imports the same package so both sides agree on the address map.
package fb_params;

  localparam int FB_WIDTH   = 1024;
  localparam int FB_HEIGHT  = 768;
  localparam int FB_DEPTH   = FB_WIDTH * FB_HEIGHT;
  localparam int X_WIDTH    = 10;
  localparam int Y_WIDTH    = 10;
  localparam int ADDR_WIDTH = 20;
  localparam int RAM_WIDTH  = 1;
  // FB_WIDTH is a power of two, so y*FB_WIDTH is a plain shift
  localparam int ROW_SHIFT  = $clog2(FB_WIDTH);

  typedef logic [X_WIDTH-1:0]    x_t;
  typedef logic [Y_WIDTH-1:0]    y_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [RAM_WIDTH-1:0]  pix_t;

  localparam x_t    X_MAX      = x_t'(FB_WIDTH - 1);
  localparam y_t    Y_MAX      = y_t'(FB_HEIGHT - 1);
  localparam addr_t ROW_STRIDE = addr_t'(FB_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DONE   = 2'd2,
    REJECT = 2'd3
  } fill_state_t;

  typedef struct packed {
    x_t   x0;
    y_t   y0;
    x_t   x1;
    y_t   y1;
    pix_t color;
  } fill_cmd_t;

  // inverted corners or a start point off the screen
  function automatic logic cmd_bad(input fill_cmd_t c);
    return (c.x0 > c.x1) || (c.y0 > c.y1) || (c.x0 > X_MAX) || (c.y0 > Y_MAX);
  endfunction

  // trim the far corner to the visible area
  function automatic fill_cmd_t cmd_clamp(input fill_cmd_t c);
    fill_cmd_t r;
    r = c;
    if (c.x1 > X_MAX) r.x1 = X_MAX;
    if (c.y1 > Y_MAX) r.y1 = Y_MAX;
    return r;
  endfunction

endpackage

// File: rtl/framebuffer_fill_engine_raster.sv
// Raster walker: x/y position plus a row-base accumulator, producing the
// registered write address and a flag when the current pixel is the last one.
module fill_raster_counter
  import fb_params::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [X_WIDTH-1:0]    ld_x,
  input  logic [Y_WIDTH-1:0]    ld_y,
  input  logic [X_WIDTH-1:0]    lo_x,
  input  logic [X_WIDTH-1:0]    hi_x,
  input  logic [Y_WIDTH-1:0]    hi_y,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  x_t    x;
  y_t    y;
  addr_t row_base;

  assign last = (x == hi_x) && (y == hi_y);

  // load the start corner, then walk x fastest and bump row_base per line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      x        <= ld_x;
      y        <= ld_y;
      row_base <= addr_t'(ld_y) << ROW_SHIFT;
      addr     <= (addr_t'(ld_y) << ROW_SHIFT) + addr_t'(ld_x);
    end else if (step) begin
      if (x == hi_x) begin
        x        <= lo_x;
        y        <= y + 1'b1;
        row_base <= row_base + ROW_STRIDE;
        addr     <= row_base + ROW_STRIDE + addr_t'(lo_x);
      end else begin
        x        <= x + 1'b1;
        addr     <= row_base + addr_t'(x) + addr_t'(1);
      end
    end
  end

endmodule

// File: rtl/framebuffer_fill_engine.sv
// Rectangle fill for the 1-bit framebuffer: accepts one command, validates and
// clamps it, then writes one pixel per clock in raster order.
module framebuffer_fill_engine
  import fb_params::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_WIDTH-1:0]    cmd_x0,
  input  logic [Y_WIDTH-1:0]    cmd_y0,
  input  logic [X_WIDTH-1:0]    cmd_x1,
  input  logic [Y_WIDTH-1:0]    cmd_y1,
  input  logic [RAM_WIDTH-1:0]  cmd_color,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  done_err,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [RAM_WIDTH-1:0]  fb_din
);

  fill_state_t state;
  fill_cmd_t   req, cmd;
  logic        accept, load, step, last;

  assign req    = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
  assign accept = cmd_valid & cmd_ready;
  assign load   = accept & ~cmd_bad(req);
  // counter holds the pixel currently on fb_addr; advance unless it is the final one
  assign step   = (state == FILL) & ~last & ~abort;

  fill_raster_counter u_raster (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .ld_x (cmd_x0),
    .ld_y (cmd_y0),
    .lo_x (cmd.x0),
    .hi_x (cmd.x1),
    .hi_y (cmd.y1),
    .addr (fb_addr),
    .last (last)
  );

  // control FSM with registered handshake, status and write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      fb_we     <= 1'b0;
      fb_din    <= '0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          // abort is ignored here, even when it coincides with accept
          if (accept) begin
            cmd       <= cmd_clamp(req);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_bad(req)) begin
              state    <= REJECT;
              done     <= 1'b1;
              done_err <= 1'b1;
            end else begin
              state  <= FILL;
              fb_we  <= 1'b1;
              fb_din <= cmd_color;
            end
          end
        end
        FILL: begin
          if (abort || last) begin
            state <= DONE;
            fb_we <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE, REJECT: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          fb_we     <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
